// File: rtl/mul_seq.sv
// mul_seq: sequential multiply-add, P = A*B + C, radix-2 shift-add.
// It retires one multiplier bit per clock and takes LEN cycles per result.
// It is the arithmetic inverse of the sequential divider:
// (quotient, denominator, remainder) -> numerator.
//
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   START  level-sampled each edge; loads A/B/C and starts (restarts) an operation
//   DONE   high when idle; P/OVF valid
//   A      multiplicand  (LEN)
//   B      multiplier    (LEN)
//   C      addend        (LEN)
//   P      result        (2*LEN), updated only on the completion edge
//   OVF    high when P[2*LEN-1:LEN] is nonzero
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | state_q == 0: registers hold, DONE high
// BUSY  | state_q != 0: one shift-add step per edge, state_q counts down
module mul_seq #(
  parameter int LEN = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic             DONE,
  input  logic [LEN-1:0]   A,
  input  logic [LEN-1:0]   B,
  input  logic [LEN-1:0]   C,
  output logic [2*LEN-1:0] P,
  output logic             OVF
);

  localparam int            SLEN  = $clog2(LEN);
  localparam logic [SLEN:0] STEPS = (SLEN+1)'(LEN);
  localparam logic [SLEN:0] ONE   = (SLEN+1)'(1);

  logic [SLEN:0]    state_q, state_d;
  logic [LEN-1:0]   arg_a_q, arg_a_d;
  logic [LEN-1:0]   acc_h_q, acc_h_d;
  logic [LEN-1:0]   acc_l_q, acc_l_d;
  logic [2*LEN-1:0] p_q, p_d;
  logic [LEN:0]     sum;
  logic             busy;

  assign busy = (state_q != '0);

  // The extra top bit keeps the carry; it lands in acc_h after the shift.
  always_comb begin
    sum = {1'b0, acc_h_q} + (acc_l_q[0] ? {1'b0, arg_a_q} : {(LEN+1){1'b0}});
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= '0;
      arg_a_q <= '0;
      acc_h_q <= '0;
      acc_l_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      arg_a_q <= arg_a_d;
      acc_h_q <= acc_h_d;
      acc_l_q <= acc_l_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arg_a_d = arg_a_q;
    acc_h_d = acc_h_q;
    acc_l_d = acc_l_q;
    p_d     = p_q;
    if (START) begin
      // Seeding acc_h with C: it is shifted down LEN times and ends up
      // added to the low half of the product.
      state_d = STEPS;
      arg_a_d = A;
      acc_h_d = C;
      acc_l_d = B;
    end else if (busy) begin
      state_d = state_q - ONE;
      acc_h_d = sum[LEN:1];
      acc_l_d = {sum[0], acc_l_q[LEN-1:1]};
      if (state_q == ONE) begin
        p_d = {sum[LEN:1], sum[0], acc_l_q[LEN-1:1]};
      end
    end
  end

  always_comb begin
    DONE = ~busy;
    OVF  = |p_q[2*LEN-1:LEN];
  end

  assign P = p_q;

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        st16;
  logic [15:0] a16, b16, c16;
  logic        done16, ovf16;
  logic [31:0] p16;

  // 5-bit instance (non-power-of-two width)
  logic        st5;
  logic [4:0]  a5, b5, c5;
  logic        done5, ovf5;
  logic [9:0]  p5;

  int total = 0;
  int bad   = 0;

  mul_seq #(.LEN(16)) dut16 (
    .CLK(clk), .RST_N(rst_n), .START(st16), .DONE(done16),
    .A(a16), .B(b16), .C(c16), .P(p16), .OVF(ovf16)
  );

  mul_seq #(.LEN(5)) dut5 (
    .CLK(clk), .RST_N(rst_n), .START(st5), .DONE(done5),
    .A(a5), .B(b5), .C(c5), .P(p5), .OVF(ovf5)
  );

  // Drive START for exactly one rising edge; returns at the following negedge.
  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    a16 = a; b16 = b; c16 = c; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
  endtask

  task automatic start5(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    a5 = a; b5 = b; c5 = c; st5 = 1'b1;
    @(negedge clk);
    st5 = 1'b0;
  endtask

  // Counts busy samples until DONE; notes whether P moved while busy.
  task automatic wait_done16(input logic [31:0] p_prev, output int lat, output bit held);
    lat = 0; held = 1'b1;
    while (done16 !== 1'b1 && lat < 200) begin
      lat++;
      if (p16 !== p_prev) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done5(input logic [9:0] p_prev, output int lat, output bit held);
    lat = 0; held = 1'b1;
    while (done5 !== 1'b1 && lat < 200) begin
      lat++;
      if (p5 !== p_prev) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    st16 = 1'b0; a16 = '0; b16 = '0; c16 = '0;
    st5 = 1'b0; a5 = '0; b5 = '0; c5 = '0;
    #1;
    total++; if (done16 !== 1'b1) begin bad++; $display("FAIL reset_done16 got=%b exp=1", done16); end
    total++; if (p16 !== 32'd0) begin bad++; $display("FAIL reset_p16 got=%0h exp=0", p16); end
    total++; if (ovf16 !== 1'b0) begin bad++; $display("FAIL reset_ovf16 got=%b exp=0", ovf16); end
    total++; if (done5 !== 1'b1 || p5 !== 10'd0) begin bad++; $display("FAIL reset_dut5 done=%b p=%0h exp done=1 p=0", done5, p5); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (done16 !== 1'b1 || p16 !== 32'd0 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset done=%b p=%0h ovf=%b exp 1/0/0", done16, p16, ovf16);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [3] = '{16'd1234, 16'hFFFF, 16'd0};
    logic [15:0] tb [3] = '{16'd53,   16'hFFFF, 16'hFFFF};
    logic [15:0] tc [3] = '{16'd25,   16'hFFFF, 16'd7};
    logic [31:0] tp [3] = '{32'd65427, 32'hFFFF0000, 32'd7};
    logic        to [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      logic [31:0] p_prev;
      int lat; bit held;
      p_prev = p16;
      start16(ta[i], tb[i], tc[i]);
      wait_done16(p_prev, lat, held);
      total++; if (lat != 16) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=16", i, lat); end
      total++; if (!held) begin bad++; $display("FAIL dir%0d_p_hold got=changed exp=held", i); end
      total++; if (p16 !== tp[i]) begin bad++; $display("FAIL dir%0d_p got=%0h exp=%0h", i, p16, tp[i]); end
      total++; if (ovf16 !== to[i]) begin bad++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf16, to[i]); end
    end
  endtask

  task automatic test_restart;
    logic [31:0] p_prev;
    int lat; bit held;
    p_prev = p16;
    start16(16'd1234, 16'd53, 16'd25);
    repeat (7) @(negedge clk);
    total++; if (p16 !== p_prev || done16 !== 1'b0) begin
      bad++; $display("FAIL restart_mid p=%0h done=%b exp p=%0h done=0", p16, done16, p_prev);
    end
    start16(16'd3, 16'd5, 16'd0);
    wait_done16(p_prev, lat, held);
    total++; if (lat != 16) begin bad++; $display("FAIL restart_latency got=%0d exp=16", lat); end
    total++; if (!held) begin bad++; $display("FAIL restart_p_hold got=changed exp=held"); end
    total++; if (p16 !== 32'd15) begin bad++; $display("FAIL restart_p got=%0h exp=f", p16); end
  endtask

  task automatic test_start_held;
    logic [31:0] p_prev;
    int lat; bit held; bit low_ok;
    p_prev = p16;
    low_ok = 1'b1;
    a16 = 16'd100; b16 = 16'd200; c16 = 16'd300; st16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done16 !== 1'b0) low_ok = 1'b0;
    end
    st16 = 1'b0;
    total++; if (!low_ok) begin bad++; $display("FAIL held_done_low got=high exp=low"); end
    wait_done16(p_prev, lat, held);
    total++; if (lat != 16 || !held) begin bad++; $display("FAIL held_latency got=%0d held=%0b exp=16 held=1", lat, held); end
    total++; if (p16 !== 32'd20300) begin bad++; $display("FAIL held_p got=%0d exp=20300", p16); end
  endtask

  task automatic test_final_step;
    logic [31:0] p_prev;
    int lat; bit held;
    p_prev = p16;
    start16(16'd7, 16'd9, 16'd1);
    repeat (15) @(negedge clk);
    start16(16'd2, 16'd3, 16'd4);
    total++; if (p16 !== p_prev || done16 !== 1'b0) begin
      bad++; $display("FAIL final_step_collision p=%0h done=%b exp p=%0h done=0", p16, done16, p_prev);
    end
    wait_done16(p_prev, lat, held);
    total++; if (lat != 16 || !held) begin bad++; $display("FAIL final_step_latency got=%0d held=%0b exp=16 held=1", lat, held); end
    total++; if (p16 !== 32'd10) begin bad++; $display("FAIL final_step_p got=%0d exp=10", p16); end
  endtask

  task automatic test_reset_mid;
    start16(16'd1234, 16'd53, 16'd25);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (done16 !== 1'b1 || p16 !== 32'd0 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL reset_mid done=%b p=%0h ovf=%b exp 1/0/0", done16, p16, ovf16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (done16 !== 1'b1 || p16 !== 32'd0) begin
      bad++; $display("FAIL reset_no_resume done=%b p=%0h exp 1/0", done16, p16);
    end
  endtask

  task automatic test_random16(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a, b, c;
      logic [31:0] exp_p, p_prev;
      int lat; bit held;
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '1;
      if ($urandom_range(0, 9) == 0) c = '1;
      exp_p = {16'd0, a} * {16'd0, b} + {16'd0, c};
      p_prev = p16;
      start16(a, b, c);
      wait_done16(p_prev, lat, held);
      total++; if (lat != 16 || !held) begin bad++; $display("FAIL rnd16_timing got lat=%0d held=%0b exp 16/1", lat, held); end
      total++; if (p16 !== exp_p || ovf16 !== (exp_p[31:16] != 0)) begin
        bad++; $display("FAIL rnd16_p a=%0d b=%0d c=%0d got=%0h ovf=%b exp=%0h", a, b, c, p16, ovf16, exp_p);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      total++; if (p16 !== exp_p || done16 !== 1'b1) begin bad++; $display("FAIL rnd16_idle_hold got=%0h exp=%0h", p16, exp_p); end
    end
  endtask

  task automatic test_back_to_back5(input int n);
    for (int i = 0; i < n; i++) begin
      logic [4:0] a, b, c;
      logic [9:0] exp_p, p_prev;
      int lat; bit held;
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
      exp_p = 10'(int'(a) * int'(b) + int'(c));
      p_prev = p5;
      start5(a, b, c);
      wait_done5(p_prev, lat, held);
      total++; if (lat != 5 || !held) begin bad++; $display("FAIL rnd5_timing got lat=%0d held=%0b exp 5/1", lat, held); end
      total++; if (p5 !== exp_p || ovf5 !== (exp_p[9:5] != 0)) begin
        bad++; $display("FAIL rnd5_p a=%0d b=%0d c=%0d got=%0d ovf=%b exp=%0d", a, b, c, p5, ovf5, exp_p);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_restart;
    test_start_held;
    test_final_step;
    test_reset_mid;
    test_random16(1500);
    test_back_to_back5(2500);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
